// File: rtl/serial_rx_pkg.sv
// Shared types and constants for the serial frame receiver.
// State encoding plus the start/stop bit polarities.
package serial_rx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/rx_shift_reg.sv
// Right-shift register for incoming serial data.
// New bits enter at the MSB so the first bit ends up at bit 0.
module rx_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic         d,
  output logic [W-1:0] q
);

  // Clear has priority; otherwise shift one bit in on enable.
  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= {d, q[W-1:1]};
    end
  end

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, DATA_W bits LSB first, stop bit.
// Holds one word for a valid/ready consumer and flags errors.
module serial_frame_rx #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              d_in,
  input  logic              bit_en,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              out_valid,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  import serial_rx_pkg::*;

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [DATA_W-1:0]   sr_q;
  logic                sr_en;

  assign sr_en = bit_en && (state == DATA);

  rx_shift_reg #(
    .W (DATA_W)
  ) u_sr (
    .clk (clk),
    .clr (reset),
    .en  (sr_en),
    .d   (d_in),
    .q   (sr_q)
  );

  // Frame FSM, bit counter and registered output/status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (bit_en) begin
        unique case (state)
          IDLE: begin
            if (d_in == START_BIT) begin
              state <= DATA;
              cnt   <= '0;
              busy  <= 1'b1;
            end
          end
          DATA: begin
            if (cnt == LAST) begin
              state <= STOP;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          STOP: begin
            state <= IDLE;
            busy  <= 1'b0;
            if (d_in == STOP_BIT) begin
              // A word still waiting with no consumer this edge wins.
              if (!out_valid || out_ready) begin
                data_out  <= sr_q;
                out_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx.
// Hand-computed words, framing errors, overrun and reset cases.
module tb_serial_frame_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       d_in;
  logic       bit_en;
  logic       out_ready;
  logic [7:0] data_out;
  logic       out_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_pass = 0;
  int n_tot  = 0;

  serial_frame_rx #(
    .DATA_W (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .d_in      (d_in),
    .bit_en    (bit_en),
    .out_ready (out_ready),
    .data_out  (data_out),
    .out_valid (out_valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tot++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // gap-1 disabled cycles with junk data, then one sampled bit.
  task automatic send_bit(input logic b, input int gap);
    for (int i = 1; i < gap; i++) begin
      bit_en = 1'b0;
      d_in   = 1'($urandom_range(0, 1));
      tick();
    end
    bit_en = 1'b1;
    d_in   = b;
    tick();
    bit_en = 1'b0;
    d_in   = 1'b1;
  endtask

  // rdy_stop >= 0 forces out_ready for the stop-bit edge.
  task automatic send_frame(input logic [7:0] w,
                            input logic stop,
                            input int gap,
                            input int rdy_stop);
    send_bit(1'b0, gap);
    check("busy_start", busy, 1);
    for (int i = 0; i < 8; i++) send_bit(w[i], gap);
    if (rdy_stop >= 0) out_ready = rdy_stop[0];
    send_bit(stop, gap);
  endtask

  initial begin
    reset     = 1'b1;
    d_in      = 1'b1;
    bit_en    = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    check("rst_data", data_out, 0);
    check("rst_valid", out_valid, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    tick();

    // Basic frame A5
    send_frame(8'hA5, 1'b1, 1, -1);
    check("a5_data", data_out, 8'hA5);
    check("a5_valid", out_valid, 1);
    check("a5_ferr", frame_err, 0);
    check("a5_busy", busy, 0);
    tick();
    check("a5_hold", data_out, 8'hA5);
    out_ready = 1'b1;
    tick();
    check("a5_consumed", out_valid, 0);
    out_ready = 1'b0;

    // Bad stop bit
    send_frame(8'hA5, 1'b0, 1, -1);
    check("ferr_pulse", frame_err, 1);
    check("ferr_valid", out_valid, 0);
    check("ferr_data", data_out, 8'hA5);
    tick();
    check("ferr_clear", frame_err, 0);
    check("ferr_busy", busy, 0);

    // Overrun: 3C kept, FF dropped
    send_frame(8'h3C, 1'b1, 1, -1);
    check("3c_data", data_out, 8'h3C);
    check("3c_ovr", overrun, 0);
    send_frame(8'hFF, 1'b1, 1, -1);
    check("ovr_pulse", overrun, 1);
    check("ovr_data", data_out, 8'h3C);
    check("ovr_valid", out_valid, 1);
    tick();
    check("ovr_once", overrun, 0);
    check("ovr_keep", data_out, 8'h3C);
    out_ready = 1'b1;
    tick();
    check("ovr_consumed", out_valid, 0);

    // Back-to-back with consume and load on one edge
    send_frame(8'h01, 1'b1, 1, -1);
    check("01_data", data_out, 8'h01);
    check("01_valid", out_valid, 1);
    out_ready = 1'b0;
    send_frame(8'h80, 1'b1, 1, 1);
    check("80_data", data_out, 8'h80);
    check("80_valid", out_valid, 1);
    check("80_ovr", overrun, 0);
    tick();
    check("80_consumed", out_valid, 0);
    out_ready = 1'b0;

    // Sparse bit_en, every 3rd cycle
    send_frame(8'h5A, 1'b1, 3, -1);
    check("5a_data", data_out, 8'h5A);
    check("5a_valid", out_valid, 1);
    check("5a_ferr", frame_err, 0);

    // Reset mid-frame with a word pending
    send_bit(1'b0, 1);
    send_bit(1'b1, 1);
    send_bit(1'b1, 1);
    send_bit(1'b0, 1);
    send_bit(1'b0, 1);
    check("c3_busy", busy, 1);
    reset  = 1'b1;
    bit_en = 1'b1;
    d_in   = 1'b0;
    out_ready = 1'b0;
    tick();
    check("mrst_data", data_out, 0);
    check("mrst_valid", out_valid, 0);
    check("mrst_busy", busy, 0);
    check("mrst_ferr", frame_err, 0);
    check("mrst_ovr", overrun, 0);
    reset  = 1'b0;
    bit_en = 1'b0;
    d_in   = 1'b1;
    tick();
    send_frame(8'h81, 1'b1, 1, -1);
    check("81_data", data_out, 8'h81);
    check("81_valid", out_valid, 1);
    check("81_ferr", frame_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
